truth_table_checker: RTL

TRUTH_TABLE_CHECKER -- requirements
Module: truth_table_checker

---
 rtl/truth_table_checker.sv | 139 +++++++++++++
 1 files changed

// File: rtl/truth_table_checker.sv
// Truth-table checker: sweeps {a,b,c} through 000..111, holding each vector
// for HOLD cycles, samples the DUT response z at the end of each window and
// compares it against the EXPECTED table. Reports mismatch count, the first
// failing vector and an overall pass flag after each sweep.
module truth_table_checker #(
    parameter logic [7:0] EXPECTED = 8'b1110_1000,
    parameter int         HOLD     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] first_fail,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Last value of the hold counter inside one vector window (HOLD <= 256).
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_vec;
    logic [7:0] r_hold;
    logic [3:0] r_err;
    logic [2:0] r_first;
    logic       r_fvalid;
    logic       r_pass;
    logic       w_sample;
    logic       w_mismatch;
    logic [3:0] w_err_next;

    // State register; reset aborts any sweep immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_sample     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = DRIVE;
                end
            end
            DRIVE: begin
                busy     = 1'b1;
                w_sample = (r_hold == HOLD_LAST);
                if (w_sample && (r_vec == 3'd7)) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // z is only meaningful at the last cycle of each vector window.
    assign w_mismatch = w_sample && (z != EXPECTED[r_vec]);
    assign w_err_next = r_err + {3'b000, w_mismatch};

    // Vector/hold sequencing and result bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec    <= 3'd0;
            r_hold   <= 8'd0;
            r_err    <= 4'd0;
            r_first  <= 3'd0;
            r_fvalid <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vec    <= 3'd0;
                        r_hold   <= 8'd0;
                        r_err    <= 4'd0;
                        r_first  <= 3'd0;
                        r_fvalid <= 1'b0;
                        r_pass   <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (w_sample) begin
                        r_err  <= w_err_next;
                        r_hold <= 8'd0;
                        if (w_mismatch && !r_fvalid) begin
                            r_first  <= r_vec;
                            r_fvalid <= 1'b1;
                        end
                        if (r_vec == 3'd7) begin
                            // Final sample already folded into the pass decision.
                            r_pass <= (w_err_next == 4'd0);
                            r_vec  <= 3'd0;
                        end else begin
                            r_vec <= r_vec + 3'd1;
                        end
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {a, b, c}  = r_vec;
    assign pass       = r_pass;
    assign err_count  = r_err;
    assign first_fail = r_first;
    assign fail_valid = r_fvalid;

endmodule
